// File: rtl/kbd_defs.sv
// Shared definitions for the PS/2 key event decoder: scan codes, FSM states,
// held-bit indices and the make/break match table.
package kbd_defs;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_e;

  localparam int IDX_UP    = 0;
  localparam int IDX_DOWN  = 1;
  localparam int IDX_ENTER = 2;
  localparam int IDX_ESC   = 3;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } key_match_t;

  // Enter matches in both classes so base and keypad Enter share one held bit.
  function automatic key_match_t match_key(input logic is_ext, input logic [7:0] code);
    key_match_t m;
    m.hit = 1'b0;
    m.idx = 2'd0;
    if (code == SC_ENTER) begin
      m.hit = 1'b1;
      m.idx = 2'(IDX_ENTER);
    end else if (!is_ext && code == SC_ESC) begin
      m.hit = 1'b1;
      m.idx = 2'(IDX_ESC);
    end else if (is_ext && code == SC_UP) begin
      m.hit = 1'b1;
      m.idx = 2'(IDX_UP);
    end else if (is_ext && code == SC_DOWN) begin
      m.hit = 1'b1;
      m.idx = 2'(IDX_DOWN);
    end
    return m;
  endfunction

endpackage

// File: rtl/kbd_prefix_timer.sv
// Watchdog for a pending prefix: expires after PREFIX_TIMEOUT cycles of
// non-idle state without a received byte.
module kbd_prefix_timer #(
  parameter int PREFIX_TIMEOUT = 100000,
  parameter int CNT_W          = 17
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expire
);

  logic [CNT_W-1:0] r_cnt;

  assign expire = run && (r_cnt == CNT_W'(PREFIX_TIMEOUT - 1));

  // Held at zero while idle so the counter can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear || expire || !run) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// PS/2 set-2 byte stream to edge-only menu key pulses, with E0/F0 prefix
// decoding, typematic suppression and a prefix timeout.
module key_event_decoder
  import kbd_defs::*;
#(
  parameter int PREFIX_TIMEOUT = 100000,
  parameter int CNT_W          = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       arrow_up,
  output logic       arrow_down,
  output logic       enter,
  output logic       esc,
  output logic [3:0] held
);

  state_e     r_state;
  logic [3:0] r_pulse;
  logic [3:0] r_held;

  logic       w_run;
  logic       w_expire;
  logic       w_is_ext;
  key_match_t w_match;
  logic [3:0] w_key_bit;

  assign w_run    = (r_state != S_IDLE);
  assign w_is_ext = (r_state == S_EXT) || (r_state == S_EXT_BRK);
  assign w_match  = match_key(w_is_ext, rx_data);

  for (genvar gi = 0; gi < 4; gi++) begin : g_key_bit
    assign w_key_bit[gi] = w_match.hit && (w_match.idx == 2'(gi));
  end

  kbd_prefix_timer #(
    .PREFIX_TIMEOUT(PREFIX_TIMEOUT),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .run   (w_run),
    .clear (rx_valid),
    .expire(w_expire)
  );

  // A received byte takes priority over a timeout in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pulse <= 4'b0000;
      r_held  <= 4'b0000;
    end else begin
      r_pulse <= 4'b0000;
      if (rx_valid) begin
        case (r_state)
          S_IDLE: begin
            if (rx_data == SC_EXT) begin
              r_state <= S_EXT;
            end else if (rx_data == SC_BRK) begin
              r_state <= S_BRK;
            end else begin
              r_pulse <= w_key_bit & ~r_held;
              r_held  <= r_held | w_key_bit;
            end
          end
          S_EXT: begin
            if (rx_data == SC_BRK) begin
              r_state <= S_EXT_BRK;
            end else if (rx_data != SC_EXT) begin
              r_pulse <= w_key_bit & ~r_held;
              r_held  <= r_held | w_key_bit;
              r_state <= S_IDLE;
            end
          end
          S_BRK, S_EXT_BRK: begin
            r_held  <= r_held & ~w_key_bit;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (w_expire) begin
        r_state <= S_IDLE;
      end
    end
  end

  assign arrow_up   = r_pulse[IDX_UP];
  assign arrow_down = r_pulse[IDX_DOWN];
  assign enter      = r_pulse[IDX_ENTER];
  assign esc        = r_pulse[IDX_ESC];
  assign held       = r_held;

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder: a behavioural model pushes the
// expected {pulses, held} per cycle, compared one cycle after the stimulus.
module tb_key_event_decoder;

  localparam int P  = 40;
  localparam int CW = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       arrow_up, arrow_down, enter, esc;
  logic [3:0] held;

  key_event_decoder #(
    .PREFIX_TIMEOUT(P),
    .CNT_W         (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .arrow_up  (arrow_up),
    .arrow_down(arrow_down),
    .enter     (enter),
    .esc       (esc),
    .held      (held)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] exp_q[$];
  bit         m_ext, m_brk;
  int         m_timer;
  logic [3:0] m_held;
  int         seen[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic int key_of(input bit ext, input logic [7:0] c);
    if (c == 8'h5A) return 2;
    if (!ext && c == 8'h76) return 3;
    if (ext && c == 8'h75) return 0;
    if (ext && c == 8'h72) return 1;
    return -1;
  endfunction

  function automatic logic [3:0] outs();
    return {esc, enter, arrow_down, arrow_up};
  endfunction

  // One clock of stimulus: model predicts, DUT is sampled 1 ns after the edge.
  task automatic tick(input bit v, input logic [7:0] d);
    logic [3:0] p;
    logic [7:0] e;
    logic [3:0] o;
    int k;
    p = 4'b0000;
    rx_valid = v;
    rx_data  = d;
    if (v) begin
      m_timer = 0;
      if (m_brk) begin
        k = key_of(m_ext, d);
        if (k >= 0) m_held[k] = 1'b0;
        m_ext = 0;
        m_brk = 0;
      end else if (d == 8'hF0) begin
        m_brk = 1;
      end else if (d == 8'hE0) begin
        m_ext = 1;
      end else begin
        k = key_of(m_ext, d);
        if (k >= 0 && !m_held[k]) begin
          p[k] = 1'b1;
          m_held[k] = 1'b1;
        end
        m_ext = 0;
      end
    end else if (m_ext || m_brk) begin
      if (m_timer == P - 1) begin
        m_ext = 0;
        m_brk = 0;
        m_timer = 0;
      end else begin
        m_timer++;
      end
    end
    exp_q.push_back({p, m_held});
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    e = exp_q.pop_front();
    o = outs();
    chk("pulses", {28'd0, o}, {28'd0, e[7:4]});
    chk("held", {28'd0, held}, {28'd0, e[3:0]});
    if ($countones(o) > 1) chk("onehot", {28'd0, o}, 32'd0);
    for (int i = 0; i < 4; i++) seen[i] += int'(o[i]);
    if (v) $display("byte %02h -> pulses %b held %b", d, o, held);
  endtask

  task automatic send(input logic [7:0] d);
    tick(1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic clr_seen();
    for (int i = 0; i < 4; i++) seen[i] = 0;
  endtask

  task automatic model_reset();
    m_ext = 0;
    m_brk = 0;
    m_timer = 0;
    m_held = 4'b0000;
    exp_q.delete();
  endtask

  logic [7:0] pool[9] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h5A, 8'h76, 8'h12, 8'h1C, 8'hE1};

  initial begin
    model_reset();
    clr_seen();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {28'd0, outs()}, 32'd0);
    chk("reset_held", {28'd0, held}, 32'd0);
    #2 reset = 1'b0;

    // Up make then extended break
    clr_seen();
    send(8'hE0); send(8'h75); idle(2);
    send(8'hE0); send(8'hF0); send(8'h75); idle(2);
    chk("up_count", seen[0], 1);

    // Typematic Esc
    clr_seen();
    send(8'h76); idle(1); send(8'h76); idle(1); send(8'h76);
    send(8'hF0); send(8'h76); send(8'h76); idle(2);
    chk("esc_count", seen[3], 2);

    // Base and keypad Enter share a held bit
    clr_seen();
    send(8'h5A); send(8'hE0); send(8'h5A); idle(1);
    chk("enter_once", seen[2], 1);
    send(8'hF0); send(8'h5A); idle(1);
    send(8'hE0); send(8'h5A); idle(1);
    chk("enter_again", seen[2], 2);
    send(8'hF0); send(8'h5A);

    // Timeout: full window expires; byte on the last cycle still wins
    clr_seen();
    send(8'hE0); idle(P); send(8'h72); idle(2);
    chk("down_timeout", seen[1], 0);
    send(8'hE0); idle(P - 1); send(8'h72); idle(2);
    chk("down_edge", seen[1], 1);
    send(8'hE0); send(8'hF0); send(8'h72);
    send(8'hE0); idle(10); send(8'h72); idle(2);
    chk("down_gap10", seen[1], 2);
    send(8'hE0); send(8'hF0); send(8'h72);

    // Unmatched / fake shift, then back-to-back down
    clr_seen();
    send(8'hE0); send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hE1);
    chk("unmatched", seen[0] + seen[1] + seen[2] + seen[3], 0);
    send(8'hE0); send(8'h72); idle(1);
    chk("down_b2b", seen[1], 1);
    send(8'hE0); send(8'hF0); send(8'h72); idle(1);

    // Asynchronous reset mid-sequence
    send(8'hE0); send(8'h75); send(8'hE0);
    #2 reset = 1'b1;
    #1;
    chk("async_outs", {28'd0, outs()}, 32'd0);
    chk("async_held", {28'd0, held}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    clr_seen();
    send(8'h75); idle(1);
    chk("no_stale_prefix", seen[0], 0);
    send(8'hE0); send(8'h75); idle(1);
    chk("up_after_reset", seen[0], 1);

    // Random byte stream
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) send(pool[$urandom_range(0, 8)]);
      else idle($urandom_range(1, 3));
    end
    idle(P + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Upstream stage of the main menu controller.
- Consumes the byte stream from the PS/2 receiver, which delivers one scan-code-set-2 byte per rx_valid strobe.
- Decodes E0 (extended) and F0 (break) prefixes.
- Emits single-cycle, edge-only pulses on arrow_up, arrow_down, enter and esc. Typematic repeat is suppressed, so a held key produces exactly one pulse per press.

Parameters:
- PREFIX_TIMEOUT, 100000, clk cycles allowed between a prefix byte and the byte that follows it before the decoder abandons the sequence (1 ms at 100 MHz).
- CNT_W, 17, timeout counter width; must satisfy 2^CNT_W > PREFIX_TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
- rx_data  in  8  received scan-code byte
- arrow_up  out  1  one-cycle pulse on Up make (E0 75)
- arrow_down  out  1  one-cycle pulse on Down make (E0 72)
- enter  out  1  one-cycle pulse on Enter make (5A, or keypad E0 5A)
- esc  out  1  one-cycle pulse on Esc make (76)
- held  out  4  level per key {esc, enter, down, up}; 1 while the key is pressed

Behaviour:
- Reset (async, active-high):
  - All pulse outputs go to 0 and held goes to 0.
  - FSM goes to S_IDLE and the timeout counter goes to 0.
  - Reset asserted mid-sequence discards the partial prefix; no pulse is emitted.
- FSM states:
  - S_IDLE: no prefix pending.
  - S_EXT: E0 seen.
  - S_BRK: F0 seen.
  - S_EXT_BRK: E0 then F0 seen.
- Transitions, evaluated only on rx_valid:
  - S_IDLE: E0 -> S_EXT; F0 -> S_BRK; other byte -> make(base, byte), stay in S_IDLE.
  - S_EXT: F0 -> S_EXT_BRK; E0 -> stay in S_EXT; other byte -> make(ext, byte), go to S_IDLE.
  - S_BRK: any byte -> break(base, byte), go to S_IDLE.
  - S_EXT_BRK: any byte -> break(ext, byte), go to S_IDLE.
- make(class, code):
  - Match table: base 5A = enter, base 76 = esc, ext 75 = up, ext 72 = down, ext 5A = enter.
  - If the code matches and the key's held bit is 0, set held and pulse the output.
  - If held is already 1 (typematic repeat), do not pulse.
  - Unmatched codes, including E0 12 and E1 sequences, are ignored. E1 is treated as an ordinary unmatched base byte.
- break(class, code): clear the matching held bit. Never pulses. A break for a key that is not held has no effect.
- Enter shares one held bit between base 5A and ext 5A.
- Latency: the pulse is registered and asserts in the cycle after the rx_valid that carries the final byte. It is high for exactly one cycle.
- At most one pulse output is high in any cycle.
- The held update is visible in the same cycle as the pulse.
- Prefix timeout:
  - The counter clears on every rx_valid and increments each cycle while the FSM is not in S_IDLE.
  - When the counter reaches PREFIX_TIMEOUT-1 with no rx_valid, the FSM returns to S_IDLE and the counter clears. No pulse is emitted and held is unchanged.
  - If rx_valid arrives in the same cycle as the timeout, the byte wins and is decoded normally.
- In S_IDLE the counter holds at 0, so it never wraps.
- rx_valid is assumed to be at most one cycle wide. Back-to-back strobes on consecutive cycles must still be decoded correctly.
- Outputs depend only on registered state; there are no combinational paths from the inputs.

Decomposition:
- Shared package/header `kbd_defs`:
  - Scan-code constants: SC_EXT=E0, SC_BRK=F0, SC_ENTER=5A, SC_ESC=76, SC_UP=75, SC_DOWN=72.
  - 2-bit FSM state encodings S_IDLE, S_EXT, S_BRK, S_EXT_BRK.
  - held bit indices: 0 = up, 1 = down, 2 = enter, 3 = esc.
- One sub-module, `kbd_prefix_timer`:
  - Inputs: clk, reset, run (FSM not idle), clear (rx_valid).
  - Output: expire.
  - Parameters: PREFIX_TIMEOUT, CNT_W.
- FSM, match table and held register stay in key_event_decoder.

Test Plan:
- Send E0, 75 -> arrow_up high exactly 1 cycle, one cycle after the 75 strobe; held=0001. Then send E0, F0, 75 -> no pulse, held=0000.
- Typematic Esc: send 76, 76, 76, then F0, 76, then 76 -> esc pulses on the first and last 76 only; held[3] is 1 between the first 76 and F0 76, and 1 again after the last 76.
- Base and keypad Enter: send 5A, then E0 5A -> one enter pulse only; a single release (F0 5A) clears held[2]; a following E0 5A pulses enter again.
- Timeout: send E0, wait PREFIX_TIMEOUT cycles, send 72 -> no arrow_down pulse (72 decoded as an unmatched base code). Repeat with a 10-cycle gap -> arrow_down pulses.
- Unmatched and fake-shift codes: send E0 12, then 1C, then F0 1C -> no pulses, held unchanged. Then send E0 72 on back-to-back cycles -> arrow_down pulses.
- Reset mid-operation: press Up (held=0001), send E0, assert reset for 1 cycle asynchronously -> all outputs 0 immediately. A following 75 (no prefix) produces no pulse; a following E0 75 pulses arrow_up.
